l1_flatten: RTL and testbench
=============================

// Module: l1_flatten
// PURPOSE
// Flatten stage downstream of the conv/max-pool engine. After both kernel channels of the
// 32x32 max-pooled layer 1 are in memory, this block reads them back through the shared
// layer-memory port. It writes them channel-interleaved into the 2048-entry layer-2 memory:
// L2[2i] = L1_k0[i], L2[2i+1] = L1_k1[i]. Values are copied unchanged; no arithmetic.
// PARAMETERS
// N_PIX   1024  pixels per L1 channel; idx counts 0..N_PIX-1
// AW      12    address width of caddr_rd / caddr_wr
// DW      20    data width (signed Q4.16 word, copied bit-exact)
// PORTS
// clk       in   1   single clock, all flops rise on posedge
// reset     in   1   asynchronous, active-low; 0 clears all state immediately
// start     in   1   one-cycle request, sampled only in IDLE
// busy      out  1   high from first RD0 cycle through last WR1 cycle
// done      out  1   one-cycle pulse after final write
// crd       out  1   memory read strobe
// caddr_rd  out  AW  read address (L1 pixel index, zero-extended)
// cdata_rd  in   DW  read data, valid in the same cycle crd/caddr_rd/csel are presented
// cwr       out  1   memory write strobe; memory captures on the posedge ending the cycle
// caddr_wr  out  AW  write address (L2 index)
// cdata_wr  out  DW  write data
// csel      out  3   memory select: 000 none, 011 L1 kernel0, 100 L1 kernel1, 101 L2
// BEHAVIOUR
// - Reset (reset=0): state=IDLE, idx=0, hold=0; all outputs 0, csel=000. Takes effect
//   asynchronously, including mid-transfer. After release, the block waits for a new start.
// - The transfer is never resumed; the next start begins again at idx=0.
// - FSM states: IDLE, RD0, WR0, RD1, WR1, DONE. Each non-IDLE state lasts exactly 1 cycle.
//   IDLE -start-> RD0 -> WR0 -> RD1 -> WR1.
//   WR1 goes to RD0 with idx+1 when idx<N_PIX-1; otherwise it goes to DONE.
//   DONE -> IDLE.
// - All outputs are registered and decoded from the registered state, idx and hold.
//   No combinational path runs from inputs to outputs.
// - RD0:  crd=1, csel=011, caddr_rd=idx, cwr=0; hold<=cdata_rd at the closing posedge.
// - WR0:  cwr=1, csel=101, caddr_wr={idx,1'b0}, cdata_wr=hold, crd=0.
// - RD1:  crd=1, csel=100, caddr_rd=idx, cwr=0; hold<=cdata_rd.
// - WR1:  cwr=1, csel=101, caddr_wr={idx,1'b1}, cdata_wr=hold, crd=0.
// - crd and cwr are never high in the same cycle. csel=000 in IDLE and DONE.
// - Strobe-deasserted addresses and data: caddr_rd, caddr_wr and cdata_wr hold their last
//   value while the matching strobe is low. The bench checks them only while strobed.
// - Latency: start sampled at posedge T0; RD0 occupies cycle T0+1. busy=1 for exactly
//   4*N_PIX cycles (4096 at default). done=1 in cycle T0+4*N_PIX+1 with busy=0 that cycle.
// - Start handling: start while busy or in DONE is ignored (no restart, no queueing).
//   start in the IDLE cycle right after DONE is accepted normally.
// - Widths: idx is 10 bits at default. Write address is {idx,parity} = 11 bits,
//   zero-extended to AW. The last write address is 2047.
//   The idx increment cannot wrap because the WR1 exit test precedes the increment.
// - Data is copied bit-exact, sign bit included. No rounding, clamping or ReLU.
//   Upstream already guarantees L1 >= 0.
// TESTING
// 1 Reset: hold reset=0 with random start/cdata_rd -> busy=done=crd=cwr=0, csel=000,
//   all addresses and data 0.
// 2 First pixel: L1_k0[0]=20'h00123, L1_k1[0]=20'h00ABC, start at T0 ->
//   T0+1: crd=1 csel=011 caddr_rd=0.
//   T0+2: cwr=1 csel=101 caddr_wr=0 cdata_wr=20'h00123.
//   T0+4: caddr_wr=1 cdata_wr=20'h00ABC.
// 3 Full run with random L1 data incl. 20'h80000 and 20'h7FFFF ->
//   L2[2i]=k0[i] and L2[2i+1]=k1[i] for all i.
//   busy high exactly 4096 cycles, one done pulse, last write caddr_wr=2047.
// 4 Start held high or re-pulsed at idx=300 -> no restart; write sequence identical to
//   scenario 3; back-to-back start right after done begins a second identical run.
// 5 reset=0 asynchronously at idx=500 mid-WR0 -> outputs 0 immediately, no further writes;
//   after release a new start resumes from caddr_rd=0 and the full run completes correctly.
// 6 Protocol monitor over whole run -> crd&cwr never 1 together;
//   csel is 011 or 100 whenever crd=1 and 101 whenever cwr=1.

Source files
------------

// File: rtl/l1_flatten.sv
// Flatten stage: copies both 32x32 layer-1 channels into layer-2 memory, channel-interleaved.
// Every output is a flop loaded from the next-state decode, so nothing combinational reaches a port.
module l1_flatten #(
  parameter int unsigned N_PIX = 1024,
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);

  localparam int unsigned IW = $clog2(N_PIX);
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_K0   = 3'b011;
  localparam logic [2:0] SEL_K1   = 3'b100;
  localparam logic [2:0] SEL_L2   = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_WR0,
    S_RD1,
    S_WR1,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [DW-1:0] hold, hold_nx;
  logic          busy_nx, done_nx, crd_nx, cwr_nx;
  logic [AW-1:0] caddr_rd_nx, caddr_wr_nx;
  logic [2:0]    csel_nx;

  // hold doubles as the write-data register: it changes only at the end of a read cycle
  assign cdata_wr = hold;

  // State, index and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      hold     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      csel     <= SEL_NONE;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      hold     <= hold_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      crd      <= crd_nx;
      cwr      <= cwr_nx;
      caddr_rd <= caddr_rd_nx;
      caddr_wr <= caddr_wr_nx;
      csel     <= csel_nx;
    end
  end

  // Next state, then output decode of the state about to be entered
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    hold_nx     = hold;
    busy_nx     = 1'b0;
    done_nx     = 1'b0;
    crd_nx      = 1'b0;
    cwr_nx      = 1'b0;
    caddr_rd_nx = caddr_rd;
    caddr_wr_nx = caddr_wr;
    csel_nx     = SEL_NONE;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RD0;
          idx_nx   = '0;
        end
      end
      S_RD0: begin
        hold_nx  = cdata_rd;
        state_nx = S_WR0;
      end
      S_WR0: state_nx = S_RD1;
      S_RD1: begin
        hold_nx  = cdata_rd;
        state_nx = S_WR1;
      end
      S_WR1: begin
        // exit test precedes the increment, so idx never wraps
        if (idx == IW'(N_PIX - 1)) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_RD0;
          idx_nx   = idx + IW'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    case (state_nx)
      S_RD0: begin
        busy_nx     = 1'b1;
        crd_nx      = 1'b1;
        csel_nx     = SEL_K0;
        caddr_rd_nx = AW'(idx_nx);
      end
      S_WR0: begin
        busy_nx     = 1'b1;
        cwr_nx      = 1'b1;
        csel_nx     = SEL_L2;
        caddr_wr_nx = AW'({idx_nx, 1'b0});
      end
      S_RD1: begin
        busy_nx     = 1'b1;
        crd_nx      = 1'b1;
        csel_nx     = SEL_K1;
        caddr_rd_nx = AW'(idx_nx);
      end
      S_WR1: begin
        busy_nx     = 1'b1;
        cwr_nx      = 1'b1;
        csel_nx     = SEL_L2;
        caddr_wr_nx = AW'({idx_nx, 1'b1});
      end
      S_DONE:  done_nx = 1'b1;
      default: done_nx = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_l1_flatten.sv
// Bench for l1_flatten: memory model on the shared port, random L1 data, and an
// interleave reference (L2[2i]=k0[i], L2[2i+1]=k1[i]) checked after every run.
module tb_l1_flatten;

  localparam int unsigned N_PIX = 1024;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 20;
  localparam int unsigned N_WR  = 2 * N_PIX;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;
  logic [2:0]    csel;

  logic [DW-1:0] k0 [N_PIX];
  logic [DW-1:0] k1 [N_PIX];
  logic [DW-1:0] l2 [N_WR];
  logic [DW-1:0] junk;
  logic [AW-1:0] wlog [$];
  int            viol;
  int            passed = 0;
  int            total  = 0;

  l1_flatten dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  // Layer memories: read data appears in the cycle the address/select is presented
  assign cdata_rd = (csel == 3'b011) ? k0[caddr_rd[9:0]] :
                    (csel == 3'b100) ? k1[caddr_rd[9:0]] : junk;

  // Write capture (mid-cycle, equivalent to the closing edge) and protocol monitor
  always @(negedge clk) begin
    if (cwr === 1'b1 && csel === 3'b101) begin
      l2[caddr_wr[10:0]] = cdata_wr;
      wlog.push_back(caddr_wr);
    end
    if (reset === 1'b1) begin
      if (crd === 1'b1 && cwr === 1'b1) viol++;
      if (crd === 1'b1 && csel !== 3'b011 && csel !== 3'b100) viol++;
      if (cwr === 1'b1 && csel !== 3'b101) viol++;
      if (busy !== 1'b1 && (crd === 1'b1 || cwr === 1'b1)) viol++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic fill_data(input bit first_px);
    for (int i = 0; i < int'(N_PIX); i++) begin
      k0[i] = DW'($urandom);
      k1[i] = DW'($urandom);
    end
    k0[5]    = 20'h80000;
    k1[5]    = 20'h7FFFF;
    k0[1023] = 20'h7FFFF;
    k1[1023] = 20'h80000;
    if (first_px) begin
      k0[0] = 20'h00123;
      k1[0] = 20'h00ABC;
    end
    for (int i = 0; i < int'(N_WR); i++) l2[i] = 'x;
    wlog.delete();
    viol = 0;
  endtask

  // One complete transfer; repulse>=0 re-pulses start when RD0 of that pixel is seen
  task automatic run_full(input bit hold_start, input int repulse, input bit idle_after,
                          input bit first_px);
    int busy_cnt, done_at, errs;
    logic done_busy;
    fill_data(first_px);
    busy_cnt  = 0;
    done_at   = 0;
    done_busy = 1'bx;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5000; c++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (repulse >= 0 && crd && csel == 3'b011 && caddr_rd == AW'(repulse)) start = 1'b1;
      if (busy === 1'b1) busy_cnt++;
      if (c == 1) chk("first_rd", {crd, csel, caddr_rd}, {1'b1, 3'b011, 12'd0});
      if (first_px && c == 2)
        chk("first_wr0", {cwr, csel, caddr_wr, cdata_wr}, {1'b1, 3'b101, 12'd0, 20'h00123});
      if (first_px && c == 4)
        chk("first_wr1", {cwr, caddr_wr, cdata_wr}, {1'b1, 12'd1, 20'h00ABC});
      if (done === 1'b1) begin
        done_at   = c;
        done_busy = busy;
        start     = 1'b0;
        break;
      end
    end
    chk("done_cycle", 64'(done_at), 64'd4097);
    chk("busy_cycles", 64'(busy_cnt), 64'd4096);
    chk("busy_at_done", 64'(done_busy), 64'd0);
    chk("wr_count", 64'(wlog.size()), 64'(N_WR));
    errs = 0;
    for (int j = 0; j < wlog.size(); j++) if (wlog[j] !== AW'(j)) errs++;
    chk("wr_order", 64'(errs), 64'd0);
    chk("last_wr", (wlog.size() > 0) ? 64'(wlog[wlog.size()-1]) : 64'hFFFF, 64'd2047);
    errs = 0;
    for (int i = 0; i < int'(N_PIX); i++) begin
      if (l2[2*i] !== k0[i]) errs++;
      if (l2[2*i+1] !== k1[i]) errs++;
    end
    chk("l2_data", 64'(errs), 64'd0);
    chk("protocol", 64'(viol), 64'd0);
    if (idle_after) begin
      repeat (3) @(negedge clk);
      chk("idle_after", {busy, done, crd, cwr}, 4'b0000);
    end
  endtask

  initial begin
    int  wsz;
    bit  found;
    reset = 1'b0;
    start = 1'b0;
    junk  = DW'($urandom);
    // Reset held with random inputs
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom);
      junk  = DW'($urandom);
      chk("reset_out", {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 64'd0);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    run_full(1'b0, -1, 1'b1, 1'b1);   // first pixel + full run
    run_full(1'b1, -1, 1'b1, 1'b0);   // start held high throughout
    run_full(1'b0, 300, 1'b1, 1'b0);  // start re-pulsed mid-transfer
    run_full(1'b0, -1, 1'b0, 1'b0);   // back-to-back pair
    run_full(1'b0, -1, 1'b1, 1'b0);

    // Asynchronous reset in WR0 of pixel 500
    fill_data(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (cwr === 1'b1 && caddr_wr == 12'd1000) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_idx500", 64'(found), 64'd1);
    #2 reset = 1'b0;
    #1 chk("async_rst_out", {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 64'd0);
    wsz = wlog.size();
    repeat (5) begin
      @(negedge clk);
      start = 1'($urandom);
    end
    chk("no_wr_in_rst", 64'(wlog.size()), 64'(wsz));
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", {busy, crd, cwr}, 3'b000);
    run_full(1'b0, -1, 1'b1, 1'b0);   // fresh run from idx 0

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
